// File: rtl/ps_pkg.sv
// rtl/ps_pkg.sv - shared types and helpers for the paralelo_serial_param converter
package ps_pkg;

    typedef enum logic {
        SYNC   = 1'b0,
        ACTIVE = 1'b1
    } ps_state_t;

    localparam logic [7:0] IDLE_SYM_DEF = 8'hBC;

    function automatic int frame_w(input int data_w, input bit parity_en);
        return data_w + (parity_en ? 1 : 0);
    endfunction

    // Even parity over the word; callers zero-extend, which leaves the XOR unchanged.
    function automatic logic even_parity(input logic [63:0] word);
        return ^word;
    endfunction

endpackage

// File: rtl/paralelo_serial_param_if.sv
// rtl/paralelo_serial_param_if.sv - word handshake and serial-line bundle of the converter
interface paralelo_serial_param_if #(
    parameter int DATA_W = 8
);
    logic              valid_in_PS;
    logic [DATA_W-1:0] data_in_PS;
    logic              ready_out_PS;
    logic              data_out_PS;
    logic              frame_start_PS;
    logic              active_PS;

    modport master (
        output valid_in_PS, data_in_PS,
        input  ready_out_PS, data_out_PS, frame_start_PS, active_PS
    );

    modport slave (
        input  valid_in_PS, data_in_PS,
        output ready_out_PS, data_out_PS, frame_start_PS, active_PS
    );
endinterface

// File: rtl/ps_shifter.sv
// rtl/ps_shifter.sv - frame load/shift register with bit counter, MSB first
module ps_shifter #(
    parameter int FRAME_W = 8
) (
    input  logic               clk_PS,
    input  logic               reset_L,
    input  logic [FRAME_W-1:0] i_frame,
    output logic               o_serial,
    output logic               o_load,
    output logic               o_frame_start
);
    localparam int CNT_W = $clog2(FRAME_W);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_W - 1);

    logic [FRAME_W-1:0] r_shift;
    logic [CNT_W-1:0]   r_bit_cnt;

    // Counter resets to LAST so the first cycle after release is a load cycle.
    always_ff @(posedge clk_PS) begin
        if (!reset_L) begin
            r_shift   <= '0;
            r_bit_cnt <= LAST;
        end else if (o_load) begin
            r_shift   <= i_frame;
            r_bit_cnt <= '0;
        end else begin
            r_shift   <= {r_shift[FRAME_W-2:0], 1'b0};
            r_bit_cnt <= r_bit_cnt + CNT_W'(1);
        end
    end

    assign o_load        = (r_bit_cnt == LAST);
    assign o_serial      = r_shift[FRAME_W-1];
    assign o_frame_start = reset_L && (r_bit_cnt == '0);

endmodule

// File: rtl/paralelo_serial_param.sv
// rtl/paralelo_serial_param.sv - parallel-to-serial TX converter with link sync and idle fill; parity bit when PS_PARITY_EN is defined
module paralelo_serial_param
    import ps_pkg::*;
#(
    parameter int                DATA_W     = 8,
    parameter logic [DATA_W-1:0] IDLE_SYM   = DATA_W'(IDLE_SYM_DEF),
    parameter int                SYNC_WORDS = 4
) (
    input  logic                     clk_PS,
    input  logic                     reset_L,
    paralelo_serial_param_if.slave   bus
);
`ifdef PS_PARITY_EN
    localparam bit PARITY_EN = 1'b1;
`else
    localparam bit PARITY_EN = 1'b0;
`endif
    localparam int FRAME_W = frame_w(DATA_W, PARITY_EN);
    localparam int SCNT_W  = $clog2(SYNC_WORDS + 1);
    localparam logic [SCNT_W-1:0] SYNC_LAST = SCNT_W'(SYNC_WORDS);

    ps_state_t          r_state, w_next_state;
    logic [SCNT_W-1:0]  r_sync_cnt, w_next_sync_cnt;
    logic               w_load, w_sync_done, w_ready;
    logic [DATA_W-1:0]  w_word;
    logic [FRAME_W-1:0] w_frame;

    always_ff @(posedge clk_PS) begin
        if (!reset_L) begin
            r_state    <= SYNC;
            r_sync_cnt <= '0;
        end else begin
            r_state    <= w_next_state;
            r_sync_cnt <= w_next_sync_cnt;
        end
    end

    assign w_sync_done = (r_sync_cnt == SYNC_LAST);
    // The final SYNC load already counts as an ACTIVE load, so ready opens on it.
    assign w_ready     = reset_L && w_load && ((r_state == ACTIVE) || w_sync_done);

    always_comb begin
        w_next_state    = r_state;
        w_next_sync_cnt = r_sync_cnt;
        w_word          = IDLE_SYM;
        if (w_ready && bus.valid_in_PS) begin
            w_word = bus.data_in_PS;
        end
        if (w_load && (r_state == SYNC)) begin
            if (w_sync_done) begin
                w_next_state = ACTIVE;
            end else begin
                w_next_sync_cnt = r_sync_cnt + SCNT_W'(1);
            end
        end
    end

`ifdef PS_PARITY_EN
    assign w_frame = {w_word, even_parity(64'(w_word))};
`else
    assign w_frame = w_word;
`endif

    ps_shifter #(
        .FRAME_W (FRAME_W)
    ) u_shifter (
        .clk_PS        (clk_PS),
        .reset_L       (reset_L),
        .i_frame       (w_frame),
        .o_serial      (bus.data_out_PS),
        .o_load        (w_load),
        .o_frame_start (bus.frame_start_PS)
    );

    assign bus.ready_out_PS = w_ready;
    assign bus.active_PS    = (r_state == ACTIVE);

endmodule

// File: doc/paralelo_serial_param.md
Name: paralelo_serial_param

Overview:
- Parametrised parallel-to-serial converter; next generation of the 8-bit PS block on the serial link TX path.
- Adds: configurable word width, ready/valid back-pressure, a link-sync phase of idle symbols after reset, idle-symbol insertion when no data, and a frame-start marker.
- Feeds the serial line; upstream is the byte/word mux stage.

Parameters:
- DATA_W, 8, parallel word width in bits (>=2).
- IDLE_SYM, 8'hBC, idle/COM symbol sent when no data; width DATA_W.
- SYNC_WORDS, 4, idle words sent after reset before data is accepted (>=1).

Ports:
- clk_PS  in  1  serial bit clock; all logic on rising edge.
- reset_L  in  1  synchronous, active-low reset.
- valid_in_PS  in  1  upstream word valid.
- data_in_PS  in  DATA_W  parallel word, MSB transmitted first.
- ready_out_PS  out  1  word accepted this cycle when high together with valid_in_PS.
- data_out_PS  out  1  serial bit.
- frame_start_PS  out  1  high while the first bit of a frame is on data_out_PS.
- active_PS  out  1  high in ACTIVE state (sync complete).

Behaviour:
- Clock and reset: one clock, clk_PS. reset_L is synchronous and active-low.
- Frame and counter: FRAME_W = DATA_W (DATA_W+1 with parity). Internal shift_reg[FRAME_W], bit_cnt, sync_cnt, state {SYNC, ACTIVE}.
- Reset (reset_L=0 at an edge):
  - shift_reg=0; bit_cnt=FRAME_W-1; sync_cnt=0; state=SYNC.
  - Outputs: data_out_PS=0, frame_start_PS=0, active_PS=0, ready_out_PS=0.
  - Reset mid-word truncates the word immediately.
- Load cycle: bit_cnt==FRAME_W-1. The first cycle after reset release is a load cycle.
  - On load, shift_reg gets the next frame and bit_cnt=0.
  - Otherwise shift_reg shifts left by 1 and bit_cnt increments.
- Outputs: data_out_PS = shift_reg[FRAME_W-1]; frame_start_PS = (bit_cnt==0) and not in reset.
- SYNC state:
  - Each load with sync_cnt<SYNC_WORDS loads IDLE_SYM and increments sync_cnt.
  - Load with sync_cnt==SYNC_WORDS moves state to ACTIVE and is treated as an ACTIVE load.
  - Exactly SYNC_WORDS idle words precede any data.
- ACTIVE state:
  - ready_out_PS = load cycle AND (state==ACTIVE OR sync_cnt==SYNC_WORDS); combinational from registers only, never from valid_in_PS.
  - On ready with valid_in_PS=1: load data_in_PS. With valid_in_PS=0: load IDLE_SYM.
  - valid_in_PS outside ready cycles is ignored; upstream holds data until accepted.
- Latency: word accepted at edge t appears MSB-first on data_out_PS from cycle t+1 through t+FRAME_W.
- Back-to-back words have no gap; throughput is 1 word per FRAME_W cycles.
- active_PS is registered and rises in the cycle after the transition load; it stays high until reset.
- An IDLE_SYM value presented as data is sent as data; no escaping.

Optional Feature:
- Macro: PS_PARITY_EN.
- Defined:
  - FRAME_W=DATA_W+1; each frame appends an even-parity bit (XOR of its DATA_W bits) transmitted last.
  - Idle words carry parity too.
  - ready_out_PS period becomes DATA_W+1.
- Undefined: FRAME_W=DATA_W, no parity bit.

Decomposition:
- Package ps_pkg: state enum (SYNC, ACTIVE), default IDLE_SYM constant 8'hBC, function frame_w(DATA_W), even-parity function.
- One sub-module, ps_shifter: FRAME_W-bit load/shift register plus bit_cnt. It outputs the serial bit, the load-cycle flag and the frame-start flag.
- Top handles the state machine, sync_cnt, handshake and frame selection.

Test Plan (DATA_W=8, IDLE_SYM=8'hBC, SYNC_WORDS=4, no parity unless stated):
- Reset then release, valid_in_PS=0:
  - data_out_PS streams 10111100 x4 and active_PS rises.
  - Idle continues 10111100.
  - frame_start_PS pulses every 8 cycles.
- Sync blocking: valid_in_PS=1, data_in_PS=8'hA5 held from reset release:
  - ready_out_PS first high on the 5th load cycle (cycle 32).
  - Cycles 33-40 carry 10100101.
- Back-to-back: words 8'h01, 8'hFF, 8'h80 offered on consecutive ready cycles:
  - Serial stream 00000001 11111111 10000000 with no idle gap.
  - ready_out_PS high exactly once per 8 cycles.
- Idle insertion: valid_in_PS drops for one load cycle between 8'h3C and 8'hC3:
  - Stream 00111100 10111100 11000011.
- Reset mid-word:
  - reset_L=0 at bit 3 of 8'hA5 → next cycle data_out_PS=0 and active_PS=0.
  - After release, 4 idle words are sent again before data.
- PS_PARITY_EN defined, data 8'h07:
  - Frame 000001111 (parity 1), 9-cycle ready period.
  - Idle frame 101111001.
